// File: rtl/cdc_wr_arbiter_pkg.sv
// cdc_wr_arbiter_pkg: shared constants and header builder for the FIFO write arbiter
package cdc_wr_arbiter_pkg;
  localparam logic [7:0] HDR_MAGIC = 8'hA5;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam int MAGIC_LSB = 24;
  localparam int ID_LSB = 16;
  localparam int SEQ_LSB = 0;
  function automatic logic [31:0] make_hdr(input logic [7:0] id, input logic [15:0] seq);
    logic [31:0] h;
    h = '0;
    h[MAGIC_LSB +: 8] = HDR_MAGIC;
    h[ID_LSB +: 8] = id;
    h[SEQ_LSB +: 16] = seq;
    return h;
  endfunction
endpackage

// File: rtl/cdc_wr_arbiter_rr_pick.sv
// cdc_wr_arbiter_rr_pick: round-robin priority encoder, first request at or after ptr wins
module cdc_wr_arbiter_rr_pick
  import cdc_wr_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);
  logic [N-1:0] rot;
  assign rot = N'({req, req} >> ptr);
  // scan from the far end so the lowest offset from ptr is the last, winning, assignment
  always_comb begin
    found = 1'b0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        idx = IW'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/cdc_wr_arbiter.sv
// cdc_wr_arbiter: packet round-robin arbiter with source/seq header in front of the FIFO write port
module cdc_wr_arbiter
  import cdc_wr_arbiter_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int DW = 32,
  parameter int IDW = 2,
  parameter int MAX_PKT = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_SRC-1:0]    src_valid,
  input  logic [N_SRC*DW-1:0] src_data,
  input  logic [N_SRC-1:0]    src_last,
  output logic [N_SRC-1:0]    src_ready,
  input  logic                fifo_full,
  output logic [DW-1:0]       fifo_din,
  output logic                fifo_wr_en,
  output logic [IDW-1:0]      cur_src,
  output logic                busy,
  output logic                pkt_err
);
  localparam int CW = $clog2(MAX_PKT);
  logic [1:0] state;
  logic [IDW-1:0] rr_ptr;
  logic [15:0] seq;
  logic [CW-1:0] word_cnt;
  logic found;
  logic [IDW-1:0] pick;
  logic [DW-1:0] cur_data;
  logic cur_valid, cur_last, accept, closing;
  cdc_wr_arbiter_rr_pick #(.N(N_SRC), .IW(IDW)) u_pick (
    .req(src_valid),
    .ptr(rr_ptr),
    .found(found),
    .idx(pick)
  );
  assign cur_data = src_data[cur_src*DW +: DW];
  assign cur_valid = src_valid[cur_src];
  assign cur_last = src_last[cur_src];
  assign accept = (state == DATA) & cur_valid & ~fifo_full;
  assign closing = accept & (cur_last | (word_cnt == CW'(MAX_PKT - 1)));
  // write port driven straight from state so a full FIFO blocks the write in the same cycle
  always_comb begin
    fifo_wr_en = (state == HDR) ? ~fifo_full : accept;
    fifo_din = (state == HDR) ? DW'(make_hdr(8'(cur_src), seq)) : (state == DATA) ? cur_data : '0;
    src_ready = (state == DATA && !fifo_full) ? N_SRC'(1) << cur_src : '0;
    busy = state != IDLE;
  end
  // grant, header, data sequencing; a grant is only released by a packet close
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      cur_src <= '0;
      seq <= '0;
      word_cnt <= '0;
      pkt_err <= 1'b0;
    end else begin
      pkt_err <= closing & ~cur_last;
      if (state == IDLE && found) begin
        cur_src <= pick;
        state <= HDR;
      end
      if (state == HDR && !fifo_full) begin
        state <= DATA;
        seq <= seq + 16'd1;
      end
      if (accept) word_cnt <= closing ? '0 : word_cnt + CW'(1);
      if (closing) begin
        state <= IDLE;
        rr_ptr <= IDW'((int'(cur_src) + 1) % N_SRC);
      end
    end
  end
endmodule

// File: tb/tb_cdc_wr_arbiter.sv
// tb_cdc_wr_arbiter: scoreboard bench, per-source expected word queues checked against the FIFO stream
module tb_cdc_wr_arbiter;
  localparam int N = 4;
  localparam int DW = 32;
  localparam int IDW = 2;
  localparam int MAXP = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] src_valid = '0;
  logic [N-1:0] src_last = '0;
  logic [N*DW-1:0] src_data = '0;
  logic fifo_full = 1'b0;
  logic [N-1:0] src_ready;
  logic [DW-1:0] fifo_din;
  logic fifo_wr_en;
  logic [IDW-1:0] cur_src;
  logic busy;
  logic pkt_err;
  int checks = 0;
  int errors = 0;
  logic [32:0] stim_q [N][$];
  logic [32:0] exp_q [N][$];
  bit rand_mode = 1'b0;
  bit full_force = 1'b0;
  int ph = 0;
  int cur = 0;
  int cnt = 0;
  int rr = 0;
  logic [15:0] seq_m = '0;
  bit err_exp = 1'b0;
  int rdy0 = 0;
  int perr_seen = 0;

  cdc_wr_arbiter #(.N_SRC(N), .DW(DW), .IDW(IDW), .MAX_PKT(MAXP)) dut (
    .clk(clk),
    .rst(rst),
    .src_valid(src_valid),
    .src_data(src_data),
    .src_last(src_last),
    .src_ready(src_ready),
    .fifo_full(fifo_full),
    .fifo_din(fifo_din),
    .fifo_wr_en(fifo_wr_en),
    .cur_src(cur_src),
    .busy(busy),
    .pkt_err(pkt_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_word(input int s, input logic [31:0] d, input bit last);
    stim_q[s].push_back({last, d});
    exp_q[s].push_back({last, d});
  endtask

  task automatic push_pkt(input int s, input int n);
    for (int i = 0; i < n; i++) push_word(s, {8'(8'h10 + s), 24'($urandom)}, i == n - 1);
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic bit pending();
    for (int s = 0; s < N; s++) if (stim_q[s].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_drain(input int budget);
    int i = 0;
    while ((ph != 0 || pending() || |src_valid) && i < budget) begin
      @(negedge clk);
      i++;
    end
    checks++;
    if (i >= budget) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d required<%0d", i, budget);
    end
  endtask

  task automatic wait_cnt(input int n, input int budget);
    int i = 0;
    while (!(ph == 2 && cnt == n) && i < budget) begin
      @(negedge clk);
      i++;
    end
    checks++;
    if (i >= budget) begin
      errors++;
      $display("FAIL word_wait_timeout actual=%0d required<%0d", i, budget);
    end
  endtask

  // source and FIFO-full driver: a word leaves its queue only after a sampled valid&ready
  initial begin : drv
    logic [N-1:0] xfer;
    logic [32:0] tmp;
    forever begin
      @(negedge clk);
      xfer = src_valid & src_ready;
      @(posedge clk);
      #1;
      for (int s = 0; s < N; s++) begin
        if (xfer[s] && stim_q[s].size() > 0) tmp = stim_q[s].pop_front();
        if (stim_q[s].size() > 0) begin
          src_valid[s] = rand_mode ? ($urandom_range(3) != 0) : 1'b1;
          src_data[s*DW +: DW] = stim_q[s][0][31:0];
          src_last[s] = stim_q[s][0][32];
        end else begin
          src_valid[s] = 1'b0;
          src_last[s] = 1'b0;
          src_data[s*DW +: DW] = '0;
        end
      end
      fifo_full = rand_mode ? ($urandom_range(3) == 0) : full_force;
    end
  end

  // monitor: parses the FIFO stream into header + data and checks against the scoreboard
  initial begin : mon
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        ph = 0;
        cnt = 0;
        rr = 0;
        seq_m = '0;
        err_exp = 1'b0;
      end else begin
        chk("pkt_err", {31'b0, pkt_err}, {31'b0, err_exp});
        err_exp = 1'b0;
        if (pkt_err) perr_seen++;
        if (src_ready[0]) rdy0++;
        if (ph == 0) begin
          chk("idle_busy", {31'b0, busy}, 32'd0);
          chk("idle_wr_en", {31'b0, fifo_wr_en}, 32'd0);
          chk("idle_din", fifo_din, 32'd0);
          chk("idle_ready", 32'(src_ready), 32'd0);
          if (|src_valid) begin
            cur = pick(src_valid, rr);
            ph = 1;
          end
        end else if (ph == 1) begin
          chk("hdr_busy", {31'b0, busy}, 32'd1);
          chk("hdr_ready", 32'(src_ready), 32'd0);
          chk("hdr_wr_en", {31'b0, fifo_wr_en}, {31'b0, ~fifo_full});
          chk("grant", 32'(cur_src), 32'(cur));
          if (fifo_wr_en) begin
            chk("header", fifo_din, {8'hA5, 8'(cur), seq_m});
            seq_m++;
            cnt = 0;
            ph = 2;
          end
        end else begin
          chk("data_busy", {31'b0, busy}, 32'd1);
          chk("data_ready", 32'(src_ready), fifo_full ? 32'd0 : 32'd1 << cur);
          chk("data_wr_en", {31'b0, fifo_wr_en}, {31'b0, src_valid[cur] & ~fifo_full});
          if (fifo_wr_en) begin
            checks++;
            if (exp_q[cur].size() == 0) begin
              errors++;
              $display("FAIL data_unexpected actual=%h required=none", fifo_din);
            end else begin
              e = exp_q[cur].pop_front();
              if (fifo_din !== e[31:0]) begin
                errors++;
                $display("FAIL data src%0d actual=%h required=%h", cur, fifo_din, e[31:0]);
              end
              cnt++;
              if (e[32] || cnt == MAXP) begin
                err_exp = !e[32];
                ph = 0;
                rr = (cur + 1) % N;
              end
            end
          end
        end
      end
    end
  end

  initial begin
    int p0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_wr_en", {31'b0, fifo_wr_en}, 32'd0);
    chk("rst_din", fifo_din, 32'd0);
    chk("rst_ready", 32'(src_ready), 32'd0);
    chk("rst_pkt_err", {31'b0, pkt_err}, 32'd0);
    chk("rst_cur_src", 32'(cur_src), 32'd0);
    rst = 1'b0;
    rdy0 = 0;
    push_word(0, 32'h11, 1'b0);
    push_word(0, 32'h22, 1'b0);
    push_word(0, 32'h33, 1'b1);
    wait_drain(50);
    chk("single_ready_cycles", 32'(rdy0), 32'd3);
    chk("single_busy_after", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      push_pkt(1, 1);
      push_pkt(2, 1);
    end
    wait_drain(100);
    push_pkt(0, 4);
    wait_cnt(1, 50);
    full_force = 1'b1;
    repeat (5) @(posedge clk);
    full_force = 1'b0;
    wait_drain(100);
    p0 = perr_seen;
    push_pkt(3, 6);
    push_pkt(0, 1);
    push_pkt(1, 1);
    wait_drain(100);
    chk("forced_close_pulses", 32'(perr_seen - p0), 32'd1);
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) == 0) push_pkt($urandom_range(N - 1), $urandom_range(1, 7));
      @(posedge clk);
      #1;
    end
    wait_drain(5000);
    rand_mode = 1'b0;
    repeat (3) @(posedge clk);
    push_pkt(1, 5);
    wait_cnt(2, 100);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_wr_en", {31'b0, fifo_wr_en}, 32'd0);
    chk("arst_din", fifo_din, 32'd0);
    chk("arst_ready", 32'(src_ready), 32'd0);
    for (int s = 0; s < N; s++) begin
      stim_q[s].delete();
      exp_q[s].delete();
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    push_pkt(3, 1);
    push_pkt(0, 2);
    wait_drain(100);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cdc_wr_arbiter.md
Name: cdc_wr_arbiter

Overview:
- Packet-level round-robin arbiter that lets N_SRC requesters in the write-clock domain share the write port of the 32-bit clock-crossing FIFO.
- Each granted packet is prefixed with a header word carrying the source id and a sequence number, so the read-side consumer can de-multiplex the single 32-bit stream.
- Sits directly in front of the FIFO write port, in the FIFO's write-clock domain.

Parameters:
N_SRC, 4, number of requesters (2..8)
DW, 32, data width; must equal the FIFO width
IDW, 2, source id width, clog2(N_SRC)
MAX_PKT, 256, maximum data words per packet before forced close

Ports:
clk  in  1  write-side clock
rst  in  1  asynchronous reset, active-high
src_valid  in  N_SRC  per-source word valid
src_data  in  N_SRC*DW  per-source data; source i occupies bits [i*DW +: DW]
src_last  in  N_SRC  per-source last-word-of-packet flag
src_ready  out  N_SRC  per-source accept; a word transfers when valid & ready
fifo_full  in  1  FIFO full flag
fifo_din  out  DW  FIFO write data
fifo_wr_en  out  1  FIFO write enable
cur_src  out  IDW  id of the currently granted source
busy  out  1  high while in HDR or DATA
pkt_err  out  1  one-cycle pulse when a packet is force-closed at MAX_PKT

Behaviour:
- Reset (async, active-high): state=IDLE, rr_ptr=0, cur_src=0, seq=0, word_cnt=0, pkt_err=0. Combinational outputs evaluate to: src_ready=0, fifo_wr_en=0, fifo_din=0, busy=0.
- States:
  - IDLE: round-robin search starts at rr_ptr and wraps modulo N_SRC. The first source with src_valid=1 is registered as cur_src and the FSM goes to HDR. If no source is valid, stay in IDLE.
  - HDR: fifo_din = {8'hA5, zero-extended cur_src in [23:16], seq[15:0]}. fifo_wr_en = ~fifo_full. On a write, go to DATA and increment seq (16-bit, wraps 0xFFFF->0). While fifo_full=1, hold in HDR.
  - DATA: src_ready[cur_src] = ~fifo_full; all other ready bits are 0. fifo_wr_en = src_valid[cur_src] & ~fifo_full. fifo_din = src_data of cur_src. Each accepted word increments word_cnt.
- Packet close: on an accepted word with src_last=1, or with word_cnt==MAX_PKT-1:
  - go to IDLE, set rr_ptr=(cur_src+1) mod N_SRC, clear word_cnt.
  - If the word had last=0 (forced close), pulse pkt_err the next cycle. The source's remaining words form a new packet when it is next granted.
- Timing:
  - fifo_wr_en, fifo_din and src_ready are combinational from registered state, fifo_full and the granted source's inputs. This gives zero write latency and cannot overflow the FIFO.
  - IDLE costs one cycle per packet. Minimum packet cost is 3 cycles (IDLE, HDR, one data word).
- Edge cases:
  - Source drops src_valid mid-packet: the grant is kept and the FSM waits indefinitely. Grant is never revoked except by last, MAX_PKT or rst.
  - fifo_full and src_valid both high: no transfer, src_ready=0, data must be held by the source.
  - fifo_din in IDLE is 0.
- Reset mid-packet: immediate return to IDLE. The partial packet is lost and seq returns to 0. The read side detects this via a header with seq=0.

Decomposition:
- Shared package:
  - HDR_MAGIC=8'hA5
  - state enum {IDLE, HDR, DATA}
  - header field offsets: MAGIC [31:24], ID [23:16], SEQ [15:0]
- Sub-module rr_pick: combinational round-robin priority encoder. Inputs are the request vector and the pointer; outputs are the found flag and the selected index.

Test Plan:
- Single source 0 sends 3 words 0x11,0x22,0x33 (last on 0x33), FIFO not full -> FIFO receives 0xA5000000, 0x11, 0x22, 0x33; src_ready[0] high 3 cycles; busy low afterwards.
- Sources 1 and 2 both hold 1-word packets continuously, from reset -> headers alternate id 1, 2, 1, 2 with seq 0, 1, 2, 3.
- fifo_full held high for 5 cycles during DATA of a 4-word packet -> fifo_wr_en=0 and src_ready=0 for exactly those 5 cycles; all 4 words still written once, in order.
- With MAX_PKT=4, source 3 sends 6 words, last on word 6 -> header(seq0), 4 words, pkt_err pulse, then header(seq1) and 2 words. The second packet is granted only after the other sources get their turns.
- rst asserted while in DATA after 2 of 5 words -> outputs are zero asynchronously. After release, the next packet header has seq=0 and rr_ptr=0.
- seq wrap: preload with 65536 one-word packets -> header after 0xFFFF carries seq 0x0000.
